// File: rtl/ad_frame_serializer.sv
// ad_frame_serializer: AD7864 channel words to a 64-bit McBSP serial frame.
// AD_FRAME_CHTAG_EN: tag words with channel number, else sign-extend data.
module ad_frame_serializer #(
   parameter int SCLK_DIV = 2,
   parameter int NCH      = 4
) (
   input  logic        clkin,
   input  logic        rst_bar,
   input  logic        conv_start,
   input  logic        smp_valid,
   input  logic [11:0] smp_data,
   input  logic        ovf_clr,
   output logic        sclk,
   output logic        fsx,
   output logic        dx,
   output logic        busy,
   output logic        ovf
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FSYNC,
      S_SHIFT,
      S_GAP
   } tx_state_t;

   localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

   logic [11:0]       bank [NCH];
   logic [16*NCH-1:0] frame;
   logic [16*NCH-1:0] shadow;

   logic [1:0] idx;
   logic [1:0] wr_idx;
   logic [2:0] full_cnt;
   logic [2:0] cnt_eff;
   logic       set_done;
   logic       accept;
   logic       hand_pend;

   tx_state_t  st;
   tx_state_t  st_nxt;
   logic [3:0] div_cnt;
   logic [3:0] div_nxt;
   logic       hph;
   logic       hph_nxt;
   logic [5:0] bit_cnt;
   logic [5:0] bit_nxt;
   logic       tick;
   logic       per_end;

   logic sclk_nxt;
   logic fsx_nxt;
   logic dx_nxt;
   logic busy_nxt;

   // A conv_start in the same cycle as a sample makes it channel 0.
   assign wr_idx   = conv_start ? 2'd0 : idx;
   assign cnt_eff  = conv_start ? 3'd0 : full_cnt;
   assign set_done = smp_valid && (cnt_eff == 3'(NCH - 1));
   assign accept   = (st == S_IDLE) && !hand_pend;

   // Capture index and fill count; conv_start drops a partial set.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         idx      <= 2'd0;
         full_cnt <= 3'd0;
      end else if (smp_valid) begin
         idx      <= wr_idx + 2'd1;
         full_cnt <= set_done ? 3'd0 : cnt_eff + 3'd1;
      end else if (conv_start) begin
         idx      <= 2'd0;
         full_cnt <= 3'd0;
      end
   end

   // Holding bank, written in channel order.
   always_ff @(posedge clkin) begin
      if (smp_valid) begin
         bank[wr_idx] <= smp_data;
      end
   end

   // Handoff request to the transmitter, or sticky overrun if it is busy.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         hand_pend <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         hand_pend <= set_done && accept;
         if (set_done && !accept) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   // Format the four bank words into one frame, word 0 first.
   always_comb begin
      frame = '0;
      for (int i = 0; i < NCH; i++) begin
`ifdef AD_FRAME_CHTAG_EN
         frame[16*(NCH-1-i) +: 16] = {2'(i), 2'b00, bank[i]};
`else
         frame[16*(NCH-1-i) +: 16] = {{4{bank[i][11]}}, bank[i]};
`endif
      end
   end

   // Shadow copy is taken only when an idle transmitter accepts a set.
   always_ff @(posedge clkin) begin
      if (st == S_IDLE && hand_pend) begin
         shadow <= frame;
      end
   end

   assign tick    = (div_cnt == DIV_LAST);
   assign per_end = tick && hph;

   // TX state and sclk timing counters.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         st      <= S_IDLE;
         div_cnt <= 4'd0;
         hph     <= 1'b0;
         bit_cnt <= 6'd0;
      end else begin
         st      <= st_nxt;
         div_cnt <= div_nxt;
         hph     <= hph_nxt;
         bit_cnt <= bit_nxt;
      end
   end

   // Next state; each sclk period is a high half then a low half.
   always_comb begin
      st_nxt  = st;
      div_nxt = 4'd0;
      hph_nxt = 1'b0;
      bit_nxt = bit_cnt;
      if (st == S_FSYNC || st == S_SHIFT || st == S_GAP) begin
         hph_nxt = hph;
         if (tick) begin
            hph_nxt = ~hph;
         end else begin
            div_nxt = div_cnt + 4'd1;
         end
      end
      unique case (st)
         S_IDLE: begin
            bit_nxt = 6'd0;
            if (hand_pend) begin
               st_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            st_nxt = S_FSYNC;
         end
         S_FSYNC: begin
            if (per_end) begin
               st_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (per_end) begin
               bit_nxt = bit_cnt + 6'd1;
               if (bit_cnt == 6'd63) begin
                  st_nxt = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (per_end) begin
               st_nxt = S_IDLE;
            end
         end
         default: begin
            st_nxt = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle; dx/fsx move with sclk rising.
   always_comb begin
      sclk_nxt = 1'b0;
      fsx_nxt  = 1'b0;
      dx_nxt   = 1'b0;
      busy_nxt = 1'b0;
      unique case (st_nxt)
         S_FSYNC: begin
            sclk_nxt = !hph_nxt;
            fsx_nxt  = 1'b1;
            busy_nxt = 1'b1;
         end
         S_SHIFT: begin
            sclk_nxt = !hph_nxt;
            dx_nxt   = shadow[~bit_nxt];
            busy_nxt = 1'b1;
         end
         S_GAP: begin
            busy_nxt = 1'b1;
         end
         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   // Registered pins keep sclk glitch-free toward the DSP.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         sclk <= 1'b0;
         fsx  <= 1'b0;
         dx   <= 1'b0;
         busy <= 1'b0;
      end else begin
         sclk <= sclk_nxt;
         fsx  <= fsx_nxt;
         dx   <= dx_nxt;
         busy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ad_frame_serializer.sv
// tb_ad_frame_serializer: directed frames on SCLK_DIV=2 and SCLK_DIV=1.
// Expected frames are hand-formatted for either word-format build.
module tb_ad_frame_serializer;

   logic        clk = 1'b0;
   logic        rst_bar = 1'b0;
   logic        conv_start = 1'b0;
   logic        smp_valid = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [11:0] smp_data = 12'h000;

   logic sclk_a, fsx_a, dx_a, busy_a, ovf_a;
   logic sclk_b, fsx_b, dx_b, busy_b, ovf_b;

   int checks = 0;
   int errors = 0;

`ifdef AD_FRAME_CHTAG_EN
   localparam logic [63:0] FR_A = 64'h0ABC_4123_8800_C7FF;
   localparam logic [63:0] FR_C = 64'h00F0_41E1_82D2_C3C3;
   localparam logic [63:0] FR_P = 64'h0111_4222_8333_C444;
   localparam logic [63:0] FR_D = 64'h0321_49A5_8456_CFED;
`else
   localparam logic [63:0] FR_A = 64'hFABC_0123_F800_07FF;
   localparam logic [63:0] FR_C = 64'h00F0_01E1_02D2_03C3;
   localparam logic [63:0] FR_P = 64'h0111_0222_0333_0444;
   localparam logic [63:0] FR_D = 64'h0321_F9A5_0456_FFED;
`endif

   always #5 clk = ~clk;

   ad_frame_serializer #(.SCLK_DIV(2)) u_dut (
      .clkin      (clk),
      .rst_bar    (rst_bar),
      .conv_start (conv_start),
      .smp_valid  (smp_valid),
      .smp_data   (smp_data),
      .ovf_clr    (ovf_clr),
      .sclk       (sclk_a),
      .fsx        (fsx_a),
      .dx         (dx_a),
      .busy       (busy_a),
      .ovf        (ovf_a)
   );

   ad_frame_serializer #(.SCLK_DIV(1)) u_dut_d1 (
      .clkin      (clk),
      .rst_bar    (rst_bar),
      .conv_start (conv_start),
      .smp_valid  (smp_valid),
      .smp_data   (smp_data),
      .ovf_clr    (ovf_clr),
      .sclk       (sclk_b),
      .fsx        (fsx_b),
      .dx         (dx_b),
      .busy       (busy_b),
      .ovf        (ovf_b)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; returns one negedge later.
   task automatic samp(input logic [11:0] d);
      smp_valid = 1'b1;
      smp_data  = d;
      @(negedge clk);
      smp_valid = 1'b0;
   endtask

   // mode 0: no conv_start, 1: separate pulse, 2: with first sample.
   task automatic send_set(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d,
                           input int mode);
      if (mode == 1) begin
         conv_start = 1'b1;
         @(negedge clk);
         conv_start = 1'b0;
      end
      if (mode == 2) begin
         conv_start = 1'b1;
      end
      samp(a);
      conv_start = 1'b0;
      samp(b);
      samp(c);
      samp(d);
   endtask

   // Receive one frame as the McBSP would, on sclk falling edges.
   task automatic run_frame(input bit sel, output logic [63:0] data,
                            output int nfs, output int bcnt,
                            output int lat);
      logic prev, s, f, d, b, seen;
      int nb, cyc;
      data = '0;
      nfs  = 0;
      bcnt = 0;
      lat  = -1;
      nb   = 0;
      cyc  = 0;
      prev = 1'b0;
      seen = 1'b0;
      b    = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         s = sel ? sclk_b : sclk_a;
         f = sel ? fsx_b : fsx_a;
         d = sel ? dx_b : dx_a;
         b = sel ? busy_b : busy_a;
         if (b) begin
            bcnt++;
            seen = 1'b1;
         end
         if (f && lat < 0) begin
            lat = cyc;
         end
         if (prev && !s) begin
            if (f) begin
               nfs++;
            end else if (nfs > 0 && nb < 64) begin
               data = {data[62:0], d};
               nb++;
            end
         end
         prev = s;
      end while (cyc < 3000 && !(seen && !b && nb == 64));
      chk("frame_done", 64'(cyc < 3000), 64'd1);
   endtask

   initial begin
      logic [63:0] got;
      logic [63:0] exp_d;
      int nfs, bcnt, lat;

      repeat (3) @(negedge clk);
      chk("rst_sclk", 64'(sclk_a), 64'd0);
      chk("rst_fsx", 64'(fsx_a), 64'd0);
      chk("rst_dx", 64'(dx_a), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_ovf", 64'(ovf_a), 64'd0);
      rst_bar = 1'b1;
      @(negedge clk);
      chk("idle_busy", 64'(busy_a), 64'd0);

      // Basic frame.
      send_set(12'hABC, 12'h123, 12'h800, 12'h7FF, 1);
      run_frame(1'b0, got, nfs, bcnt, lat);
      chk("basic_data", got, FR_A);
      chk("basic_nfs", 64'(nfs), 64'd1);
      chk("basic_busy", 64'(bcnt), 64'd264);
      chk("basic_lat", 64'(lat), 64'd2);
      chk("basic_ovf", 64'(ovf_a), 64'd0);

      // Overrun during SHIFT.
      send_set(12'hABC, 12'h123, 12'h800, 12'h7FF, 1);
      fork
         run_frame(1'b0, got, nfs, bcnt, lat);
         begin
            repeat (40) @(negedge clk);
            send_set(12'h555, 12'h666, 12'h777, 12'h888, 1);
         end
      join
      chk("ovr_data", got, FR_A);
      chk("ovr_flag", 64'(ovf_a), 64'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovr_clr", 64'(ovf_a), 64'd0);
      send_set(12'h0F0, 12'h1E1, 12'h2D2, 12'h3C3, 2);
      run_frame(1'b0, got, nfs, bcnt, lat);
      chk("ovr_next_data", got, FR_C);
      chk("ovr_next_ovf", 64'(ovf_a), 64'd0);

      // Partial set discarded by conv_start.
      conv_start = 1'b1;
      @(negedge clk);
      conv_start = 1'b0;
      samp(12'hEEE);
      samp(12'hDDD);
      send_set(12'h111, 12'h222, 12'h333, 12'h444, 1);
      run_frame(1'b0, got, nfs, bcnt, lat);
      chk("part_data", got, FR_P);
      chk("part_ovf", 64'(ovf_a), 64'd0);

      // Reset in the high half of bit 20.
      send_set(12'h321, 12'h9A5, 12'h456, 12'hFED, 1);
      repeat (86) @(negedge clk);
      exp_d = FR_D;
      chk("pre_rst_sclk", 64'(sclk_a), 64'd1);
      chk("pre_rst_busy", 64'(busy_a), 64'd1);
      chk("pre_rst_dx", 64'(dx_a), 64'(exp_d[43]));
      #1 rst_bar = 1'b0;
      #1;
      chk("arst_sclk", 64'(sclk_a), 64'd0);
      chk("arst_fsx", 64'(fsx_a), 64'd0);
      chk("arst_dx", 64'(dx_a), 64'd0);
      chk("arst_busy", 64'(busy_a), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_bar = 1'b1;
      @(negedge clk);
      send_set(12'h321, 12'h9A5, 12'h456, 12'hFED, 0);
      run_frame(1'b0, got, nfs, bcnt, lat);
      chk("post_rst_data", got, FR_D);
      chk("post_rst_nfs", 64'(nfs), 64'd1);
      chk("post_rst_busy", 64'(bcnt), 64'd264);

      // SCLK_DIV=1, next set completes on the first IDLE cycle.
      rst_bar = 1'b0;
      @(negedge clk);
      rst_bar = 1'b1;
      @(negedge clk);
      send_set(12'h0F0, 12'h1E1, 12'h2D2, 12'h3C3, 1);
      fork
         run_frame(1'b1, got, nfs, bcnt, lat);
         begin
            repeat (20) @(negedge clk);
            conv_start = 1'b1;
            @(negedge clk);
            conv_start = 1'b0;
            samp(12'hABC);
            samp(12'h123);
            samp(12'h800);
         end
      join
      chk("d1_data", got, FR_C);
      chk("d1_busy", 64'(bcnt), 64'd132);
      chk("d1_lat", 64'(lat), 64'd2);
      samp(12'h7FF);
      run_frame(1'b1, got, nfs, bcnt, lat);
      chk("d1_b2b_lat", 64'(lat), 64'd2);
      chk("d1_b2b_ovf", 64'(ovf_b), 64'd0);
      chk("d1_b2b_data", got, FR_A);
      chk("d1_b2b_nfs", 64'(nfs), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
